// File: rtl/hazard_match_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_match_pipe_if
// Brief   : Decode-side request and hazard-control response bundle for
//           hazard_match_pipe.
// Revision: 1.0 - initial release
// ============================================================================
interface hazard_match_pipe_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    // Decode-stage instruction description and branch resolution
    logic              ValidD;
    logic [ADDR_W-1:0] RA1D;
    logic [ADDR_W-1:0] RA2D;
    logic [ADDR_W-1:0] WA3D;
    logic              RegWriteD;
    logic              MemtoRegD;
    logic              BranchTakenE;

    // Forwarding compares and pipeline control
    logic              Match_1E_M;
    logic              Match_1E_W;
    logic              Match_2E_M;
    logic              Match_2E_W;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic [CNT_W-1:0]  LdrStallCount;

    modport master (
        output ValidD, RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, BranchTakenE,
        input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
        input  RegWriteM, RegWriteW, StallF, StallD, FlushD, FlushE,
        input  LdrStallCount
    );

    modport slave (
        input  ValidD, RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, BranchTakenE,
        output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
        output RegWriteM, RegWriteW, StallF, StallD, FlushD, FlushE,
        output LdrStallCount
    );
endinterface
`default_nettype wire

// File: rtl/hazard_match_pipe.sv
`default_nettype none
// ============================================================================
// Module  : hazard_match_pipe
// Brief   : E/M/W register-address pipeline producing forwarding matches,
//           load-use stall/flush controls and a saturating stall counter.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_match_pipe #(
    parameter int ADDR_W = 4,
    parameter int PC_REG = 15,
    parameter int CNT_W  = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    hazard_match_pipe_if.slave   hz
);

    localparam logic [ADDR_W-1:0] C_PC_ADDR = ADDR_W'(PC_REG);
    localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX = {CNT_W{1'b1}};

    // Execute stage
    logic              valid_e_q,    valid_e_d;
    logic [ADDR_W-1:0] ra1_e_q,      ra1_e_d;
    logic [ADDR_W-1:0] ra2_e_q,      ra2_e_d;
    logic [ADDR_W-1:0] wa3_e_q,      wa3_e_d;
    logic              regwrite_e_q, regwrite_e_d;
    logic              memtoreg_e_q, memtoreg_e_d;

    // Memory and Writeback stages; load-ness only matters while in Execute
    logic              valid_m_q,    valid_m_d;
    logic [ADDR_W-1:0] wa3_m_q,      wa3_m_d;
    logic              regwrite_m_q, regwrite_m_d;
    logic              valid_w_q,    valid_w_d;
    logic [ADDR_W-1:0] wa3_w_q,      wa3_w_d;
    logic              regwrite_w_q, regwrite_w_d;

    logic [CNT_W-1:0]  cnt_q,        cnt_d;

    logic              w_ldr;
    logic              w_flush_e;

    // ------------------------------------------------------------------
    // Load-use detection: the branch squashes the dependent instruction,
    // so a taken branch suppresses the stall.
    // ------------------------------------------------------------------
    always_comb begin
        w_ldr = valid_e_q & memtoreg_e_q & regwrite_e_q & hz.ValidD
              & (wa3_e_q != C_PC_ADDR)
              & ((hz.RA1D == wa3_e_q) | (hz.RA2D == wa3_e_q))
              & ~hz.BranchTakenE;
        w_flush_e = w_ldr | hz.BranchTakenE;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        valid_e_d    = 1'b0;
        ra1_e_d      = '0;
        ra2_e_d      = '0;
        wa3_e_d      = '0;
        regwrite_e_d = 1'b0;
        memtoreg_e_d = 1'b0;
        if (!w_flush_e) begin
            valid_e_d    = hz.ValidD;
            ra1_e_d      = hz.RA1D;
            ra2_e_d      = hz.RA2D;
            wa3_e_d      = hz.WA3D;
            regwrite_e_d = hz.RegWriteD;
            memtoreg_e_d = hz.MemtoRegD;
        end

        valid_m_d    = valid_e_q;
        wa3_m_d      = wa3_e_q;
        regwrite_m_d = regwrite_e_q;

        valid_w_d    = valid_m_q;
        wa3_w_d      = wa3_m_q;
        regwrite_w_d = regwrite_m_q;

        cnt_d = cnt_q;
        if (w_ldr && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + C_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_e_q    <= 1'b0;
            ra1_e_q      <= '0;
            ra2_e_q      <= '0;
            wa3_e_q      <= '0;
            regwrite_e_q <= 1'b0;
            memtoreg_e_q <= 1'b0;
            valid_m_q    <= 1'b0;
            wa3_m_q      <= '0;
            regwrite_m_q <= 1'b0;
            valid_w_q    <= 1'b0;
            wa3_w_q      <= '0;
            regwrite_w_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            valid_e_q    <= valid_e_d;
            ra1_e_q      <= ra1_e_d;
            ra2_e_q      <= ra2_e_d;
            wa3_e_q      <= wa3_e_d;
            regwrite_e_q <= regwrite_e_d;
            memtoreg_e_q <= memtoreg_e_d;
            valid_m_q    <= valid_m_d;
            wa3_m_q      <= wa3_m_d;
            regwrite_m_q <= regwrite_m_d;
            valid_w_q    <= valid_w_d;
            wa3_w_q      <= wa3_w_d;
            regwrite_w_q <= regwrite_w_d;
            cnt_q        <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the PC is written through its own path, so it never matches
    // ------------------------------------------------------------------
    always_comb begin
        hz.Match_1E_M = valid_e_q & valid_m_q & (ra1_e_q == wa3_m_q) & (ra1_e_q != C_PC_ADDR);
        hz.Match_1E_W = valid_e_q & valid_w_q & (ra1_e_q == wa3_w_q) & (ra1_e_q != C_PC_ADDR);
        hz.Match_2E_M = valid_e_q & valid_m_q & (ra2_e_q == wa3_m_q) & (ra2_e_q != C_PC_ADDR);
        hz.Match_2E_W = valid_e_q & valid_w_q & (ra2_e_q == wa3_w_q) & (ra2_e_q != C_PC_ADDR);

        hz.RegWriteM     = valid_m_q & regwrite_m_q;
        hz.RegWriteW     = valid_w_q & regwrite_w_q;
        hz.StallF        = w_ldr;
        hz.StallD        = w_ldr;
        hz.FlushD        = hz.BranchTakenE;
        hz.FlushE        = w_flush_e;
        hz.LdrStallCount = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_match_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_match_pipe
// Brief   : Directed scoreboard bench; a 16-bit-counter and a 2-bit-counter
//           instance share the same Decode stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_match_pipe;

    logic clk;
    logic rst;

    hazard_match_pipe_if #(.ADDR_W(4), .CNT_W(16)) ifa ();
    hazard_match_pipe_if #(.ADDR_W(4), .CNT_W(2))  ifb ();

    hazard_match_pipe #(.ADDR_W(4), .PC_REG(15), .CNT_W(16)) u_dut_a (
        .clk   (clk),
        .reset (rst),
        .hz    (ifa)
    );

    hazard_match_pipe #(.ADDR_W(4), .PC_REG(15), .CNT_W(2)) u_dut_b (
        .clk   (clk),
        .reset (rst),
        .hz    (ifb)
    );

    assign ifb.ValidD       = ifa.ValidD;
    assign ifb.RA1D         = ifa.RA1D;
    assign ifb.RA2D         = ifa.RA2D;
    assign ifb.WA3D         = ifa.WA3D;
    assign ifb.RegWriteD    = ifa.RegWriteD;
    assign ifb.MemtoRegD    = ifa.MemtoRegD;
    assign ifb.BranchTakenE = ifa.BranchTakenE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected flags: {m1m, m1w, m2m, m2w, rwm, rww, stall, flushD, flushE}
    typedef struct {
        string      tag;
        logic [8:0] f;
        int         c16;
        int         c2;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Monitor: every cycle presents a full output set
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [9:0] act;
            logic [9:0] req;
            e   = sb.pop_front();
            act = {ifa.Match_1E_M, ifa.Match_1E_W, ifa.Match_2E_M, ifa.Match_2E_W,
                   ifa.RegWriteM, ifa.RegWriteW, ifa.StallF, ifa.StallD,
                   ifa.FlushD, ifa.FlushE};
            req = {e.f[8:3], e.f[2], e.f[2], e.f[1:0]};
            n_vec++;
            if (act !== req) begin
                n_fail++;
                $display("FAIL %s flags: got %b want %b", e.tag, act, req);
            end
            if (ifb.Match_1E_M !== ifa.Match_1E_M || ifb.FlushE !== ifa.FlushE ||
                ifb.StallF !== ifa.StallF || ifb.RegWriteW !== ifa.RegWriteW) begin
                n_fail++;
                $display("FAIL %s cnt2-instance flags: got %b%b%b%b want %b%b%b%b", e.tag,
                         ifb.Match_1E_M, ifb.FlushE, ifb.StallF, ifb.RegWriteW,
                         req[9], req[0], req[3], req[4]);
            end
            if (ifa.LdrStallCount !== 16'(e.c16)) begin
                n_fail++;
                $display("FAIL %s count16: got %0d want %0d", e.tag, ifa.LdrStallCount, e.c16);
            end
            if (ifb.LdrStallCount !== 2'(e.c2)) begin
                n_fail++;
                $display("FAIL %s count2: got %0d want %0d", e.tag, ifb.LdrStallCount, e.c2);
            end
        end
    end

    task automatic cyc(input string tag, input logic r,
                       input logic v, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] wa, input logic rw, input logic mt,
                       input logic br, input logic [8:0] ex,
                       input int c16, input int c2);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        ifa.ValidD       = v;
        ifa.RA1D         = a1;
        ifa.RA2D         = a2;
        ifa.WA3D         = wa;
        ifa.RegWriteD    = rw;
        ifa.MemtoRegD    = mt;
        ifa.BranchTakenE = br;
        e.tag = tag;
        e.f   = ex;
        e.c16 = c16;
        e.c2  = c2;
        sb.push_back(e);
    endtask

    task automatic idle(input string tag, input logic r, input logic [8:0] ex,
                        input int c16, input int c2);
        cyc(tag, r, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, ex, c16, c2);
    endtask

    initial begin
        rst              = 1'b1;
        ifa.ValidD       = 1'b0;
        ifa.RA1D         = '0;
        ifa.RA2D         = '0;
        ifa.WA3D         = '0;
        ifa.RegWriteD    = 1'b0;
        ifa.MemtoRegD    = 1'b0;
        ifa.BranchTakenE = 1'b0;
        repeat (2) @(posedge clk);

        // Reset then idle
        idle("reset_idle", 1'b0, 9'b0000_00_000, 0, 0);

        // Back-to-back ALU forward from M, then from W
        cyc("add_r1",  0, 1, 4'd3, 4'd4,  4'd1,  1, 0, 0, 9'b0000_00_000, 0, 0);
        cyc("sub_r1",  0, 1, 4'd1, 4'd5,  4'd6,  1, 0, 0, 9'b0000_00_000, 0, 0);
        cyc("fwd_1EM", 0, 1, 4'd7, 4'd8,  4'd9,  1, 0, 0, 9'b1000_10_000, 0, 0);
        cyc("rd_r6",   0, 1, 4'd6, 4'd10, 4'd11, 1, 0, 0, 9'b0000_11_000, 0, 0);
        idle("fwd_1EW",  0, 9'b0100_11_000, 0, 0);
        idle("drain_a1", 0, 9'b0000_11_000, 0, 0);
        idle("drain_a2", 0, 9'b0000_01_000, 0, 0);

        // Load-use single-cycle stall
        cyc("ldr_r2",   0, 1, 4'd3, 4'd0, 4'd2, 1, 1, 0, 9'b0000_00_000, 0, 0);
        cyc("ldr_use",  0, 1, 4'd4, 4'd2, 4'd5, 1, 0, 0, 9'b0000_00_101, 0, 0);
        cyc("ldr_held", 0, 1, 4'd4, 4'd2, 4'd5, 1, 0, 0, 9'b0000_10_000, 1, 1);
        idle("fwd_2EW",  0, 9'b0001_01_000, 1, 1);
        idle("drain_b1", 0, 9'b0000_10_000, 1, 1);
        idle("drain_b2", 0, 9'b0000_01_000, 1, 1);

        // PC exclusion for matches and load-use
        cyc("wr_pc",    0, 1, 4'd0,  4'd0,  4'd15, 1, 0, 0, 9'b0000_00_000, 1, 1);
        cyc("rd_pc",    0, 1, 4'd15, 4'd3,  4'd4,  1, 0, 0, 9'b0000_00_000, 1, 1);
        cyc("pc_nomat", 0, 1, 4'd0,  4'd0,  4'd15, 1, 1, 0, 9'b0000_10_000, 1, 1);
        cyc("pc_nostl", 0, 1, 4'd15, 4'd15, 4'd6,  1, 0, 0, 9'b0000_11_000, 1, 1);
        idle("pc_nomat2", 0, 9'b0000_11_000, 1, 1);
        idle("drain_c1",  0, 9'b0000_11_000, 1, 1);
        idle("drain_c2",  0, 9'b0000_01_000, 1, 1);

        // Branch wins over load-use
        cyc("ldr_r3",   0, 1, 4'd0, 4'd0, 4'd3, 1, 1, 0, 9'b0000_00_000, 1, 1);
        cyc("br_vs_ld", 0, 1, 4'd3, 4'd7, 4'd8, 1, 0, 1, 9'b0000_00_011, 1, 1);
        idle("drain_d1", 0, 9'b0000_10_000, 1, 1);
        idle("drain_d2", 0, 9'b0000_01_000, 1, 1);

        // Simultaneous M and W forwards; RegWrite gating by stage bit
        cyc("wr_r1",  0, 1, 4'd0, 4'd0, 4'd1, 1, 0, 0, 9'b0000_00_000, 1, 1);
        cyc("wr_r2",  0, 1, 4'd0, 4'd0, 4'd2, 1, 0, 0, 9'b0000_00_000, 1, 1);
        cyc("rd_2_1", 0, 1, 4'd2, 4'd1, 4'd3, 0, 0, 0, 9'b0000_10_000, 1, 1);
        idle("fwd_MW",   0, 9'b1001_11_000, 1, 1);
        idle("rw0_in_M", 0, 9'b0000_01_000, 1, 1);
        idle("rw0_in_W", 0, 9'b0000_00_000, 1, 1);

        // Reset mid-operation discards in-flight state
        cyc("pre_rst", 0, 1, 4'd0, 4'd0, 4'd1, 1, 0, 0, 9'b0000_00_000, 1, 1);
        cyc("in_rst",  1, 1, 4'd1, 4'd1, 4'd2, 1, 0, 0, 9'b0000_00_000, 1, 1);
        idle("post_rst", 0, 9'b0000_00_000, 0, 0);

        // Five load-use stalls: 2-bit count saturates at 3
        for (int i = 1; i <= 5; i++) begin
            int k;
            k = i - 1;
            cyc("sat_ldr", 0, 1, 4'd0, 4'd0, 4'd2, 1, 1, 0,
                (i == 1) ? 9'b0000_00_000 : 9'b0100_01_000, k, (k > 3) ? 3 : k);
            cyc("sat_use", 0, 1, 4'd2, 4'd9, 4'd9, 1, 0, 0,
                (i == 1) ? 9'b0000_00_101 : 9'b0000_10_101, k, (k > 3) ? 3 : k);
            cyc("sat_held", 0, 1, 4'd2, 4'd9, 4'd9, 1, 0, 0,
                (i == 1) ? 9'b0000_10_000 : 9'b0000_11_000, i, (i > 3) ? 3 : i);
        end
        idle("sat_rst",   1, 9'b0100_01_000, 5, 3);
        idle("cnt_clear", 0, 9'b0000_00_000, 0, 0);

        for (int t = 0; t < 10; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
